sr_resp: RTL and testbench

// Clocked responder modelling one 8-bit asynchronous static RAM chip on the far end of the SRAM bus.
// Its inputs come from the SRAM controller's registered sr_* outputs, and it returns read data on sr_d_in.

---
 rtl/sr_pkg.sv | 27 ++
 rtl/sr_resp_mem.sv | 26 ++
 rtl/sr_resp.sv | 153 +++++++++++++++
 tb/tb_sr_resp.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the SRAM chip responder: FSM state encoding,
// error register bit positions and the default "data not valid" pattern.
package sr_pkg;

   // Bus-phase state of the responder as seen at each rising edge
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEL   = 2'd1,
      ST_READ  = 2'd2,
      ST_WRITE = 2'd3
   } sr_state_e;

   // Sticky error register bit positions
   localparam int ERR_WE_SHORT = 0;
   localparam int ERR_ADR_CHG  = 1;
   localparam int ERR_CONT     = 2;
   localparam int ERR_UNDRV    = 3;
   localparam int ERR_W        = 4;

   // Pattern returned on the read bus whenever data is not valid
   localparam logic [7:0] INV_DATA_DEF = 8'hA5;

   // WE# low-time counter width and its saturation value
   localparam int         WE_CNT_W   = 3;
   localparam logic [2:0] WE_CNT_MAX = 3'd7;

endpackage

// File: rtl/sr_resp_mem.sv
// Byte-wide storage array of the modelled SRAM chip: asynchronous read
// port, synchronous write port. The contents are never reset, like a
// real static RAM.
module sr_resp_mem #(
   parameter int ADR_W = 10
) (
   input  logic             cp2_i,
   input  logic             we_i,
   input  logic [ADR_W-1:0] adr_i,
   input  logic [7:0]       din_i,
   input  logic [ADR_W-1:0] rd_adr_i,
   output logic [7:0]       dout_o
);

   logic [7:0] mem_q [2**ADR_W];

   // Write port: store one byte on the rising edge when enabled
   always_ff @(posedge cp2_i) begin
      if (we_i) begin
         mem_q[adr_i] <= din_i;
      end
   end

   assign dout_o = mem_q[rd_adr_i];

endmodule

// File: rtl/sr_resp.sv
// Clocked responder modelling one 8-bit asynchronous SRAM chip on the
// far side of the AVR external data memory bus. It serves reads with a
// configurable access latency, commits writes when WE# is released, and
// watches the bus for protocol violations, latching them in a sticky
// error register.
module sr_resp
   import sr_pkg::*;
#(
   parameter int         ADR_W    = 10,
   parameter int         ACC_LAT  = 0,
   parameter int         MIN_WE   = 1,
   parameter logic [7:0] INV_DATA = INV_DATA_DEF
) (
   input  logic         ireset,
   input  logic         cp2,
   input  logic [15:0]  sr_adr,
   input  logic [7:0]   sr_d_out,
   input  logic         sr_d_oe,
   input  logic         sr_we_n,
   input  logic         sr_cs_n,
   input  logic         sr_oe_n,
   output logic [7:0]   sr_d_in,
   output logic         wr_stb,
   output logic [3:0]   err,
   input  logic         err_clr
);

   // Latency counter only needs to reach ACC_LAT; keep at least one bit
   localparam int              LAT_W    = (ACC_LAT < 1) ? 1 : $clog2(ACC_LAT + 1);
   localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(ACC_LAT);
   localparam logic [31:0]     MIN_WE_U = MIN_WE;

   // Saturating increment of the read latency counter
   function automatic logic [LAT_W-1:0] sat_lat(input logic [LAT_W-1:0] v);
      return (v >= LAT_MAX) ? v : v + LAT_W'(1);
   endfunction

   // Saturating increment of the WE# low-time counter
   function automatic logic [WE_CNT_W-1:0] sat_we(input logic [WE_CNT_W-1:0] v);
      return (v == WE_CNT_MAX) ? v : v + 3'd1;
   endfunction

   // Combinational bus decode; WE# dominates OE#
   logic rd_act;
   logic wr_act;
   assign rd_act = ~sr_cs_n & ~sr_oe_n & sr_we_n;
   assign wr_act = ~sr_cs_n & ~sr_we_n;

   // Control state (reset)
   sr_state_e          state_q,   state_d;
   logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
   logic [WE_CNT_W-1:0] we_cnt_q, we_cnt_d;
   logic               wr_stb_q,  wr_stb_d;
   logic [ERR_W-1:0]   err_q,     err_d;

   // Data latches (not reset)
   logic [15:0]        adr_prev_q;
   logic [15:0]        wr_adr_q,  wr_adr_d;
   logic [7:0]         wr_dat_q,  wr_dat_d;

   logic               in_write;
   logic               wr_entry;
   logic               commit;
   logic [ERR_W-1:0]   err_set;
   logic [7:0]         mem_rd;

   assign in_write = (state_q == ST_WRITE);
   assign wr_entry = wr_act & ~in_write;
   // Leaving WRITE is the edge that commits the pending byte
   assign commit   = in_write & ~wr_act;

   // Next-state, counter, latch and error-register logic
   always_comb begin
      state_d = ST_SEL;
      if (sr_cs_n) begin
         state_d = ST_IDLE;
      end else if (wr_act) begin
         state_d = ST_WRITE;
      end else if (rd_act) begin
         state_d = ST_READ;
      end

      // A read restarts its access time whenever the address moves
      lat_cnt_d = '0;
      if (rd_act && (sr_adr == adr_prev_q)) begin
         lat_cnt_d = sat_lat(lat_cnt_q);
      end

      we_cnt_d = we_cnt_q;
      if (wr_entry) begin
         we_cnt_d = 3'd1;
      end else if (in_write && wr_act) begin
         we_cnt_d = sat_we(we_cnt_q);
      end

      wr_adr_d = wr_entry ? sr_adr : wr_adr_q;
      // Keep the last byte seen while WE# was low
      wr_dat_d = wr_act ? sr_d_out : wr_dat_q;

      wr_stb_d = commit;

      err_set               = '0;
      err_set[ERR_WE_SHORT] = commit && ({29'd0, we_cnt_q} < MIN_WE_U);
      err_set[ERR_ADR_CHG]  = in_write && (sr_adr != wr_adr_q);
      err_set[ERR_CONT]     = sr_d_oe & rd_act;
      err_set[ERR_UNDRV]    = wr_act & ~sr_d_oe;

      // A new violation on the clearing edge still leaves its bit set
      err_d = (err_clr ? '0 : err_q) | err_set;
   end

   // Control registers: FSM, counters, strobe and sticky errors
   always_ff @(posedge cp2 or negedge ireset) begin
      if (!ireset) begin
         state_q   <= ST_IDLE;
         lat_cnt_q <= '0;
         we_cnt_q  <= '0;
         wr_stb_q  <= 1'b0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
         we_cnt_q  <= we_cnt_d;
         wr_stb_q  <= wr_stb_d;
         err_q     <= err_d;
      end
   end

   // Data latches: previous address, pending write address and byte
   always_ff @(posedge cp2) begin
      adr_prev_q <= sr_adr;
      wr_adr_q   <= wr_adr_d;
      wr_dat_q   <= wr_dat_d;
   end

   // Storage array; a reset in progress suppresses any commit
   sr_resp_mem #(
      .ADR_W (ADR_W)
   ) u_mem (
      .cp2_i    (cp2),
      .we_i     (commit & ireset),
      .adr_i    (wr_adr_q[ADR_W-1:0]),
      .din_i    (wr_dat_q),
      .rd_adr_i (sr_adr[ADR_W-1:0]),
      .dout_o   (mem_rd)
   );

   // Asynchronous read path: valid once the access time has elapsed
   assign sr_d_in = (ireset && rd_act && (lat_cnt_q == LAT_MAX)) ? mem_rd : INV_DATA;
   assign wr_stb  = wr_stb_q;
   assign err     = err_q;

endmodule

// File: tb/tb_sr_resp.sv
// Bench for sr_resp: two instances share one bus, one with same-cycle
// reads and MIN_WE=1, one with ACC_LAT=2 and MIN_WE=2. A behavioural
// model tracks memory contents, write pulses, read stability and errors.
module tb_sr_resp;

   logic        ireset = 1'b0;
   logic        cp2    = 1'b0;
   logic [15:0] adr    = 16'h0000;
   logic [7:0]  dout   = 8'h00;
   logic        d_oe   = 1'b0;
   logic        we_n   = 1'b1;
   logic        cs_n   = 1'b1;
   logic        oe_n   = 1'b1;
   logic        err_clr = 1'b0;

   logic [7:0]  d_in0, d_in1;
   logic        stb0, stb1;
   logic [3:0]  err0, err1;

   int total = 0;
   int bad   = 0;

   always #5 cp2 = ~cp2;

   sr_resp #(.ADR_W(10), .ACC_LAT(0), .MIN_WE(1)) dut0 (
      .ireset(ireset), .cp2(cp2), .sr_adr(adr), .sr_d_out(dout), .sr_d_oe(d_oe),
      .sr_we_n(we_n), .sr_cs_n(cs_n), .sr_oe_n(oe_n), .sr_d_in(d_in0),
      .wr_stb(stb0), .err(err0), .err_clr(err_clr));

   sr_resp #(.ADR_W(10), .ACC_LAT(2), .MIN_WE(2)) dut1 (
      .ireset(ireset), .cp2(cp2), .sr_adr(adr), .sr_d_out(dout), .sr_d_oe(d_oe),
      .sr_we_n(we_n), .sr_cs_n(cs_n), .sr_oe_n(oe_n), .sr_d_in(d_in1),
      .wr_stb(stb1), .err(err1), .err_clr(err_clr));

   // ---------------- behavioural reference model ----------------
   logic [7:0]  mem_m [1024];
   bit          known [1024];
   int          wlen;       // edges WE# has been low in the current pulse
   logic [15:0] padr;
   logic [7:0]  pdat;
   int          stable;     // edges a read has been held at one address
   logic [15:0] prev_adr = 16'h0000;
   logic [3:0]  em0, em1;
   logic        exp_stb;

   task automatic model_reset();
      wlen = 0; stable = 0; em0 = 4'h0; em1 = 4'h0; exp_stb = 1'b0;
   endtask

   task automatic model_edge();
      bit rd, wr, short_p;
      logic [3:0] set;
      if (!ireset) begin
         model_reset();
         prev_adr = adr;
         return;
      end
      rd = !cs_n && !oe_n && we_n;
      wr = !cs_n && !we_n;
      set = 4'h0; short_p = 1'b0; exp_stb = 1'b0;
      if (wlen > 0 && adr != padr) set[1] = 1'b1;
      if (d_oe && rd)              set[2] = 1'b1;
      if (wr && !d_oe)             set[3] = 1'b1;
      if (wlen > 0 && !wr) begin
         mem_m[padr[9:0]] = pdat;
         known[padr[9:0]] = 1'b1;
         exp_stb = 1'b1;
         short_p = (wlen < 2);
         wlen = 0;
      end
      if (wr) begin
         if (wlen == 0) padr = adr;
         pdat = dout;
         wlen++;
      end
      stable   = (rd && adr == prev_adr) ? stable + 1 : 0;
      prev_adr = adr;
      em0 = (err_clr ? 4'h0 : em0) | set;
      em1 = (err_clr ? 4'h0 : em1) | set | {3'b000, short_p};
   endtask

   function automatic logic [7:0] exp_din(input int lat);
      bit rd;
      rd = ireset && !cs_n && !oe_n && we_n;
      return (rd && stable >= lat) ? mem_m[adr[9:0]] : 8'hA5;
   endfunction

   function automatic bit din_checkable(input int lat);
      bit rd;
      rd = ireset && !cs_n && !oe_n && we_n;
      return !(rd && stable >= lat) || known[adr[9:0]];
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic cs, input logic we, input logic oe, input logic doe,
                        input logic [15:0] a, input logic [7:0] d);
      cs_n = cs; we_n = we; oe_n = oe; d_oe = doe; adr = a; dout = d;
   endtask

   task automatic cycle();
      @(posedge cp2);
      model_edge();
      @(negedge cp2);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      ireset = 1'b0;
      model_reset();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0012, 8'h00);
      repeat (3) cycle();
      total++; if (d_in0 !== 8'hA5) begin bad++; $display("FAIL reset_din0 got=%h exp=a5", d_in0); end
      total++; if (d_in1 !== 8'hA5) begin bad++; $display("FAIL reset_din1 got=%h exp=a5", d_in1); end
      total++; if (err0 !== 4'h0 || err1 !== 4'h0) begin bad++; $display("FAIL reset_err got=%h/%h exp=0", err0, err1); end
      total++; if (stb0 !== 1'b0 || stb1 !== 1'b0) begin bad++; $display("FAIL reset_stb got=%b/%b exp=0", stb0, stb1); end
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0012, 8'h00);
      ireset = 1'b1;
      cycle();
   endtask

   task automatic test_write_read();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0012, 8'h3C);
      cycle();
      total++; if (stb0 !== 1'b0) begin bad++; $display("FAIL wr_stb_early got=%b exp=0", stb0); end
      cycle();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0012, 8'h3C);
      cycle();
      total++; if (stb0 !== 1'b1 || stb1 !== 1'b1) begin bad++; $display("FAIL wr_stb got=%b/%b exp=1", stb0, stb1); end
      total++; if (err0 !== 4'h0 || err1 !== 4'h0) begin bad++; $display("FAIL wr_err got=%h/%h exp=0", err0, err1); end
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0012, 8'h00);
      cycle();
      total++; if (stb0 !== 1'b0) begin bad++; $display("FAIL wr_stb_once got=%b exp=0", stb0); end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0012, 8'h00);
      #1;
      total++; if (d_in0 !== 8'h3C) begin bad++; $display("FAIL rd_same_cycle got=%h exp=3c", d_in0); end
      cycle();
      total++; if (d_in1 !== 8'hA5) begin bad++; $display("FAIL rd_lat_short got=%h exp=a5", d_in1); end
      cycle();
      total++; if (d_in1 !== 8'h3C) begin bad++; $display("FAIL rd_lat2 got=%h exp=3c", d_in1); end
      total++; if (err1 !== 4'h0) begin bad++; $display("FAIL rd_err got=%h exp=0", err1); end
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0012, 8'h00);
      cycle();
   endtask

   task automatic test_min_we();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0020, 8'h5A);
      cycle();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0020, 8'h5A);
      cycle();
      total++; if (stb1 !== 1'b1) begin bad++; $display("FAIL short_commit got=%b exp=1", stb1); end
      total++; if (err1 !== 4'b0001) begin bad++; $display("FAIL we_short got=%b exp=0001", err1); end
      total++; if (err0 !== 4'b0000) begin bad++; $display("FAIL we_ok_minwe1 got=%b exp=0000", err0); end
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0020, 8'h00);
      err_clr = 1'b1;
      cycle();
      err_clr = 1'b0;
      total++; if (err1 !== 4'b0000) begin bad++; $display("FAIL err_clr got=%b exp=0000", err1); end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0020, 8'h00);
      #1;
      total++; if (d_in0 !== 8'h5A) begin bad++; $display("FAIL short_data got=%h exp=5a", d_in0); end
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0020, 8'h00);
      cycle();
   endtask

   task automatic test_adr_change();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0012, 8'h99);
      cycle();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0013, 8'h99);
      cycle();
      total++; if (err0 !== 4'b0010 || err1 !== 4'b0010) begin bad++; $display("FAIL adr_chg got=%b/%b exp=0010", err0, err1); end
      drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0013, 8'h99);
      cycle();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0012, 8'h00);
      #1;
      total++; if (d_in0 !== 8'h99) begin bad++; $display("FAIL adr_chg_commit got=%h exp=99", d_in0); end
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0013, 8'h00);
      #1;
      total++; if (d_in0 !== 8'hA5) begin bad++; $display("FAIL cs_idle_din got=%h exp=a5", d_in0); end
      err_clr = 1'b1;
      cycle();
      err_clr = 1'b0;
   endtask

   task automatic test_contention();
      drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0030, 8'h00);
      cycle();
      total++; if (err0 !== 4'b0100 || err1 !== 4'b0100) begin bad++; $display("FAIL contention got=%b/%b exp=0100", err0, err1); end
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0030, 8'h00);
      err_clr = 1'b1;
      cycle();
      err_clr = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0030, 8'hE1);
      cycle();
      total++; if (err0 !== 4'b1000) begin bad++; $display("FAIL undriven got=%b exp=1000", err0); end
      drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0030, 8'h00);
      cycle();
      total++; if (err1 !== 4'b1001) begin bad++; $display("FAIL undriven_short got=%b exp=1001", err1); end
      drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0030, 8'h00);
      err_clr = 1'b1;
      cycle();
      err_clr = 1'b0;
      total++; if (err0 !== 4'b0100 || err1 !== 4'b0100) begin bad++; $display("FAIL clr_vs_set got=%b/%b exp=0100", err0, err1); end
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0030, 8'h00);
      err_clr = 1'b1;
      cycle();
      err_clr = 1'b0;
   endtask

   task automatic test_alias();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0405, 8'h77);
      cycle();
      cycle();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0405, 8'h77);
      cycle();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0005, 8'h00);
      cycle();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0005, 8'h00);
      #1;
      total++; if (d_in0 !== 8'h77) begin bad++; $display("FAIL alias0 got=%h exp=77", d_in0); end
      cycle();
      cycle();
      total++; if (d_in1 !== 8'h77) begin bad++; $display("FAIL alias1 got=%h exp=77", d_in1); end
      total++; if (err0 !== 4'h0 || err1 !== 4'h0) begin bad++; $display("FAIL alias_err got=%h/%h exp=0", err0, err1); end
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0005, 8'h00);
      cycle();
   endtask

   task automatic test_reset_mid_write();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0005, 8'hAA);
      cycle();
      cycle();
      ireset = 1'b0;
      model_reset();
      #1;
      total++; if (d_in0 !== 8'hA5 || d_in1 !== 8'hA5) begin bad++; $display("FAIL rst_mid_din got=%h/%h exp=a5", d_in0, d_in1); end
      drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0005, 8'hAA);
      cycle();
      total++; if (stb0 !== 1'b0 || stb1 !== 1'b0) begin bad++; $display("FAIL rst_mid_stb got=%b/%b exp=0", stb0, stb1); end
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0005, 8'h00);
      cycle();
      ireset = 1'b1;
      cycle();
      total++; if (err0 !== 4'h0 || err1 !== 4'h0) begin bad++; $display("FAIL rst_mid_err got=%h/%h exp=0", err0, err1); end
      total++; if (d_in0 !== 8'hA5) begin bad++; $display("FAIL rst_mid_idle got=%h exp=a5", d_in0); end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0005, 8'h00);
      #1;
      total++; if (d_in0 !== 8'h77) begin bad++; $display("FAIL rst_mid_nocommit got=%h exp=77", d_in0); end
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0005, 8'h00);
      cycle();
   endtask

   task automatic test_random();
      logic [15:0] adr_tab [6];
      logic [15:0] a;
      logic        w;
      adr_tab = '{16'h0012, 16'h0013, 16'h0405, 16'h0005, 16'h03FF, 16'hFFFF};
      a = 16'h0012;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3) == 0) a = adr_tab[$urandom_range(5)];
         w = ($urandom_range(2) != 0);
         drive(($urandom_range(7) == 0), w, $urandom_range(1) == 1,
               w ? ($urandom_range(5) == 0) : ($urandom_range(5) != 0),
               a, 8'($urandom));
         err_clr = ($urandom_range(9) == 0);
         cycle();
         total++; if (stb0 !== exp_stb || stb1 !== exp_stb) begin bad++; $display("FAIL rnd_stb i=%0d got=%b/%b exp=%b", i, stb0, stb1, exp_stb); end
         total++; if (err0 !== em0) begin bad++; $display("FAIL rnd_err0 i=%0d got=%b exp=%b", i, err0, em0); end
         total++; if (err1 !== em1) begin bad++; $display("FAIL rnd_err1 i=%0d got=%b exp=%b", i, err1, em1); end
         if (din_checkable(0)) begin
            total++; if (d_in0 !== exp_din(0)) begin bad++; $display("FAIL rnd_din0 i=%0d got=%h exp=%h", i, d_in0, exp_din(0)); end
         end
         if (din_checkable(2)) begin
            total++; if (d_in1 !== exp_din(2)) begin bad++; $display("FAIL rnd_din1 i=%0d got=%h exp=%h", i, d_in1, exp_din(2)); end
         end
      end
      err_clr = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 1'b0, a, 8'h00);
      cycle();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         known[i] = 1'b0;
         mem_m[i] = 8'h00;
      end
      padr = 16'h0000;
      pdat = 8'h00;
      model_reset();
      @(negedge cp2);
      test_reset();
      test_write_read();
      test_min_we();
      test_adr_change();
      test_contention();
      test_alias();
      test_reset_mid_write();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
